riscv_mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter for the RISC-V pipeline. It shares a single unified memory port between instruction fetch (IF) and data memory access (DM). Data requests have fixed priority over fetch, and the address phase stays locked until the memory grants. Response routing uses an in-order source-ID queue. It sits inside `riscv_pipeline_top`, between the IF/MEM stages and the memory model.

---
 rtl/riscv_arb_pkg.sv | 30 +++
 rtl/riscv_arb_id_fifo.sv | 90 +++++++++
 rtl/riscv_mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_arb_pkg.sv
// -----------------------------------------------------------------------------
// riscv_arb_pkg
//   Shared types and helpers for the instruction-fetch / data-memory arbiter.
//   - arb_state_e : arbiter address-phase state
//   - src_e       : requester identity carried through the in-order ID queue
//   - arb_cnt_w   : width of a counter that must hold the values 0..n
//   - arb_ptr_w   : width of a pointer into a queue of the given depth
// -----------------------------------------------------------------------------
package riscv_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_HOLD_IF = 2'd1,
        ARB_HOLD_DM = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_DM = 1'b1
    } src_e;

    function automatic int unsigned arb_cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int unsigned arb_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/riscv_arb_id_fifo.sv
// -----------------------------------------------------------------------------
// riscv_arb_id_fifo
//   In-order queue of requester IDs (src_e) for transactions granted by the
//   memory but not yet answered. Pointers wrap modulo DEPTH, so any depth
//   (not only powers of two) is supported.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high; empties the queue
//   push      in   enqueue push_src (accepted when not full, or full with pop)
//   push_src  in   ID to enqueue
//   pop       in   dequeue head (ignored when empty)
//   head_src  out  ID at the head of the queue
//   full      out  queue holds DEPTH entries
//   empty     out  queue holds no entries
//   count     out  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module riscv_arb_id_fifo
    import riscv_arb_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = arb_ptr_w(DEPTH),
    localparam int unsigned CNT_W = arb_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  src_e             push_src,
    input  logic             pop,
    output src_e             head_src,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    src_e             entry_q [DEPTH];
    src_e             entry_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push_ok;
    logic pop_ok;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_src = entry_q[rd_ptr_q];

    // When full, a simultaneous pop frees the head slot, which is exactly
    // where the write pointer points, so the push may proceed.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    always_comb begin
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            entry_d[wr_ptr_q] = push_src;
            wr_ptr_d          = ptr_next(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: only slots covered by count are read.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter
//   Shares one unified memory port between instruction fetch (IF) and data
//   memory access (DM). DM has fixed priority; once a source is presented to
//   memory without a grant, the address phase is locked to that source until
//   mem_gnt. Responses return in order and are routed by an ID queue.
//   Request and response paths are combinational (zero latency).
//
// Optional feature (macro RISCV_ARB_STARVE_GUARD_EN):
//   A fetch starvation counter; after STARVE_LIMIT cycles of IF waiting, IF
//   wins the next arbitration from ARB_IDLE even if DM is requesting.
//   Without the macro, DM priority is strict and no counter exists.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   if_req/if_addr                     fetch request (read only)
//   if_gnt/if_rvalid/if_rdata          fetch grant and response
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata data request
//   dm_gnt/dm_rvalid/dm_rdata          data grant and response
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  memory request
//   mem_gnt/mem_rvalid/mem_rdata       memory grant and response
// -----------------------------------------------------------------------------
module riscv_mem_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned CNT_W = arb_cnt_w(MAX_OUTSTANDING);
    localparam int unsigned BE_W  = DATA_W / 8;

    if (MAX_OUTSTANDING < 1) begin : g_bad_max_outstanding
        $error("riscv_mem_arbiter: MAX_OUTSTANDING must be at least 1");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("riscv_mem_arbiter: STARVE_LIMIT must be at least 1");
    end

    arb_state_e       state_q, state_d;
    src_e             sel_src;
    logic             sel_req;
    logic             issue_ok;
    logic             grant;
    logic             drive;
    logic             starve_force;

    src_e             head_src;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             rsp_ok;

    // ---------------------------------------------------------------- select
    // Hold states pin the selection so the address phase cannot switch
    // sources while memory is stalling or the issue window is closed.
    always_comb begin
        sel_src = SRC_DM;
        sel_req = 1'b0;
        case (state_q)
            ARB_HOLD_IF: begin
                sel_src = SRC_IF;
                sel_req = if_req;
            end
            ARB_HOLD_DM: begin
                sel_src = SRC_DM;
                sel_req = dm_req;
            end
            default: begin
                if (starve_force) begin
                    sel_src = SRC_IF;
                    sel_req = 1'b1;
                end else if (dm_req) begin
                    sel_src = SRC_DM;
                    sel_req = 1'b1;
                end else if (if_req) begin
                    sel_src = SRC_IF;
                    sel_req = 1'b1;
                end
            end
        endcase
    end

    // Issue window uses only the registered occupancy; a response arriving
    // this cycle frees its slot from the next cycle on.
    assign issue_ok = (fifo_count < CNT_W'(MAX_OUTSTANDING));
    assign mem_req  = sel_req & issue_ok & ~reset;
    assign grant    = mem_req & mem_gnt;
    assign if_gnt   = grant & (sel_src == SRC_IF);
    assign dm_gnt   = grant & (sel_src == SRC_DM);

    // Payload is zero whenever nothing is selected so idle outputs stay 0.
    assign drive     = sel_req & ~reset;
    assign mem_addr  = !drive ? '0 : (sel_src == SRC_DM) ? dm_addr : if_addr;
    assign mem_we    = drive & (sel_src == SRC_DM) & dm_we;
    assign mem_be    = !drive ? '0 : (sel_src == SRC_DM) ? dm_be : {BE_W{1'b1}};
    assign mem_wdata = (drive && sel_src == SRC_DM) ? dm_wdata : '0;

    // ------------------------------------------------------------ next state
    always_comb begin
        state_d = state_q;
        if (state_q == ARB_IDLE) begin
            if (sel_req && !grant) begin
                state_d = (sel_src == SRC_DM) ? ARB_HOLD_DM : ARB_HOLD_IF;
            end
        end else if (grant) begin
            state_d = ARB_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------- ID queue
    riscv_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (grant),
        .push_src (sel_src),
        .pop      (mem_rvalid & ~reset),
        .head_src (head_src),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // -------------------------------------------------------------- routing
    // A response with nothing outstanding (e.g. after reset abandoned a
    // transaction) is swallowed rather than routed to a stale owner.
    assign rsp_ok    = mem_rvalid & ~fifo_empty & ~reset;
    assign if_rvalid = rsp_ok & (head_src == SRC_IF);
    assign dm_rvalid = rsp_ok & (head_src == SRC_DM);
    assign if_rdata  = rsp_ok ? mem_rdata : '0;
    assign dm_rdata  = rsp_ok ? mem_rdata : '0;

    // ------------------------------------------------------- starvation guard
`ifdef RISCV_ARB_STARVE_GUARD_EN
    localparam int unsigned SC_W = arb_cnt_w(STARVE_LIMIT);

    logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

    // Forcing is only considered from ARB_IDLE; the select block applies it
    // only in that state, so an in-progress DM address phase is never broken.
    assign starve_force = if_req & (starve_cnt_q == SC_W'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_gnt) begin
            starve_cnt_d = '0;
        end else if (if_req && starve_cnt_q != SC_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    // ------------------------------------------------------------ assertions
    a_rvalid_empty_queue : assert property (
        @(posedge clk) disable iff (reset) !(mem_rvalid && fifo_empty)
    ) else $error("riscv_mem_arbiter: mem_rvalid with empty ID queue dropped");

    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (reset) !(grant && fifo_full && !mem_rvalid)
    ) else $error("riscv_mem_arbiter: grant issued with ID queue full");

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
module tb_riscv_mem_arbiter;
    import riscv_arb_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BE_W    = DATA_W / 8;
    localparam int MAX_OUT = 2;
    localparam int STARVE  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt, if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req, dm_we;
    logic [BE_W-1:0]   dm_be;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt, dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_req, mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt, mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    riscv_mem_arbiter #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .MAX_OUTSTANDING (MAX_OUT),
        .STARVE_LIMIT    (STARVE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_be      (dm_be),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        src_e              src;
        logic [DATA_W-1:0] data;
    } rsp_t;

    rsp_t sb_q[$];
    rsp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic any_out();
        return |{mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_gnt, if_rvalid,
                 if_rdata, dm_gnt, dm_rvalid, dm_rdata};
    endfunction

    function automatic src_e starve_grant_src(input int k);
`ifdef RISCV_ARB_STARVE_GUARD_EN
        return (k == STARVE + 1) ? SRC_IF : SRC_DM;
`else
        return SRC_DM;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory returns one response this cycle; remember where it must land.
    task automatic expect_rsp(input src_e src, input logic [DATA_W-1:0] data);
        rsp_t e;
        e.src  = src;
        e.data = data;
        sb_q.push_back(e);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
    endtask

    // Response monitor: every routed response must match the scoreboard head.
    always @(negedge clk) begin
        if (if_rvalid === 1'b1 || dm_rvalid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("rsp_unexpected", {62'd0, if_rvalid, dm_rvalid}, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("rsp_route", {62'd0, if_rvalid, dm_rvalid},
                         (mon_e.src == SRC_DM) ? 64'd1 : 64'd2);
                check_eq("rsp_data", (mon_e.src == SRC_DM) ? dm_rdata : if_rdata,
                         64'(mon_e.data));
            end
        end
    end

    initial begin
        src_e sg;
        logic got_if;
        logic if_done;

        reset = 1'b1;
        if_req = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;

        // Reset state
        tick(); tick();
        @(negedge clk);
        check_eq("rst_outputs", any_out(), 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_idle", any_out(), 0);
        tick();

        // Simultaneous requests: DM first, IF next cycle, responses DM then IF
        if_req = 1; if_addr = 32'h100;
        dm_req = 1; dm_addr = 32'h2000; dm_we = 0; dm_be = 4'hF;
        mem_gnt = 1;
        @(negedge clk);
        check_eq("sim_dm_gnt", dm_gnt, 1);
        check_eq("sim_if_gnt0", if_gnt, 0);
        check_eq("sim_addr_dm", mem_addr, 32'h2000);
        tick();
        dm_req = 0; dm_we = 1; dm_be = 4'h0; dm_wdata = 32'hDEAD;
        @(negedge clk);
        check_eq("sim_if_gnt", if_gnt, 1);
        check_eq("sim_dm_gnt0", dm_gnt, 0);
        check_eq("sim_addr_if", mem_addr, 32'h100);
        check_eq("if_we_zero", mem_we, 0);
        check_eq("if_be_ones", mem_be, 4'hF);
        tick();
        if_req = 0; mem_gnt = 0; dm_we = 0; dm_be = 4'hF; dm_wdata = '0;
        expect_rsp(SRC_DM, 32'hD1);
        @(negedge clk);
        tick();
        expect_rsp(SRC_IF, 32'h11);
        @(negedge clk);
        tick();
        mem_rvalid = 0;

        // Address lock: DM held for 3 stalled cycles, granted on the 4th
        dm_req = 1; dm_addr = 32'h2000;
        if_req = 1; if_addr = 32'h100;
        mem_gnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("lock_addr", mem_addr, 32'h2000);
            check_eq("lock_req", mem_req, 1);
            check_eq("lock_no_gnt", {dm_gnt, if_gnt}, 0);
            tick();
        end
        mem_gnt = 1;
        @(negedge clk);
        check_eq("lock_dm_gnt", dm_gnt, 1);
        check_eq("lock_if_gnt0", if_gnt, 0);
        check_eq("lock_addr4", mem_addr, 32'h2000);
        tick();
        // IF presented but stalled; a later DM request must not steal the phase
        dm_req = 0; mem_gnt = 0;
        @(negedge clk);
        check_eq("hold_if_addr0", mem_addr, 32'h100);
        tick();
        dm_req = 1; dm_addr = 32'h3000;
        @(negedge clk);
        check_eq("hold_if_addr1", mem_addr, 32'h100);
        check_eq("hold_if_no_dm", dm_gnt, 0);
        tick();
        mem_gnt = 1;
        @(negedge clk);
        check_eq("hold_if_gnt", if_gnt, 1);
        check_eq("hold_dm_gnt0", dm_gnt, 0);
        tick();

        // Queue full: two outstanding, no issue despite requests and mem_gnt
        if_addr = 32'h104;
        @(negedge clk);
        check_eq("full_req0", mem_req, 0);
        check_eq("full_no_gnt", {dm_gnt, if_gnt}, 0);
        tick();
        expect_rsp(SRC_DM, 32'hD2);
        @(negedge clk);
        check_eq("full_same_cyc", mem_req, 0);
        tick();
        mem_rvalid = 0;
        @(negedge clk);
        check_eq("full_reissue", mem_req, 1);
        check_eq("full_dm_addr", mem_addr, 32'h3000);
        check_eq("full_dm_gnt", dm_gnt, 1);
        tick();
        dm_req = 0;
        @(negedge clk);
        check_eq("full_if_gated", mem_req, 0);
        tick();
        expect_rsp(SRC_IF, 32'h12);
        @(negedge clk);
        check_eq("full_if_gated2", mem_req, 0);
        tick();
        mem_rvalid = 0;
        @(negedge clk);
        check_eq("full_if_gnt", if_gnt, 1);
        check_eq("full_if_addr", mem_addr, 32'h104);
        tick();
        if_req = 0; mem_gnt = 0;
        expect_rsp(SRC_DM, 32'hD3);
        @(negedge clk);
        tick();
        expect_rsp(SRC_IF, 32'h13);
        @(negedge clk);
        tick();
        mem_rvalid = 0;

        // Write passes through; its response goes to DM only
        dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h40; dm_wdata = 32'hCAFEBABE;
        mem_gnt = 1;
        @(negedge clk);
        check_eq("wr_we", mem_we, 1);
        check_eq("wr_be", mem_be, 4'b0011);
        check_eq("wr_addr", mem_addr, 32'h40);
        check_eq("wr_wdata", mem_wdata, 32'hCAFEBABE);
        check_eq("wr_dm_gnt", dm_gnt, 1);
        tick();
        dm_req = 0; dm_we = 0; dm_be = 4'hF; mem_gnt = 0;
        expect_rsp(SRC_DM, 32'h5A5A);
        @(negedge clk);
        tick();
        mem_rvalid = 0;

        // Starvation: DM requests continuously, memory answers every cycle
        dm_req = 1; dm_addr = 32'h80; if_req = 1; if_addr = 32'h180;
        mem_gnt = 1;
        if_done = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k >= 2) begin
                sg = starve_grant_src(k - 1);
                expect_rsp(sg, DATA_W'(k));
            end
            @(negedge clk);
            sg = starve_grant_src(k);
            check_eq("starve_if_gnt", if_gnt, (sg == SRC_IF) ? 1 : 0);
            check_eq("starve_dm_gnt", dm_gnt, (sg == SRC_DM) ? 1 : 0);
            got_if = if_gnt;
            tick();
            if (got_if) if_done = 1;
            if_req = !if_done;
        end
        dm_req = 0; if_req = 0; mem_gnt = 0;
        expect_rsp(starve_grant_src(8), DATA_W'(9));
        @(negedge clk);
        tick();
        mem_rvalid = 0;

        // Reset mid-flight: abandoned response is dropped
        if_req = 1; if_addr = 32'h200; mem_gnt = 1;
        @(negedge clk);
        check_eq("mid_if_gnt", if_gnt, 1);
        tick();
        reset = 1; if_req = 0; dm_req = 1; dm_addr = 32'h300; mem_gnt = 1;
        @(negedge clk);
        check_eq("mid_rst_outputs", any_out(), 0);
        tick();
        mem_rvalid = 1; mem_rdata = 32'h77;
        @(negedge clk);
        check_eq("mid_rst_rvalid", {if_rvalid, dm_rvalid}, 0);
        check_eq("mid_rst_outputs2", any_out(), 0);
        tick();
        reset = 0; mem_rvalid = 0; dm_req = 0; mem_gnt = 0;
        @(negedge clk);
        check_eq("mid_post_idle", any_out(), 0);
        tick();
        dm_req = 1; dm_addr = 32'h44; mem_gnt = 1;
        @(negedge clk);
        check_eq("mid_new_dm_gnt", dm_gnt, 1);
        tick();
        dm_req = 0; mem_gnt = 0;
        expect_rsp(SRC_DM, 32'h99);
        @(negedge clk);
        tick();
        mem_rvalid = 0;

        @(negedge clk);
        check_eq("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
